// File: rtl/fc_layer_serializer_pkg.sv
// fc_pkg: shared types and helpers for fc_layer_serializer.
//   state_e  : serializer FSM states (IDLE, SEND)
//   idx_w    : element index width for a given vector length
//   sext_shl : sign-extend an in_w-bit value to 64 bits, then shift left
package fc_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sign extension via shift-up / arithmetic shift-down, so the
  // source width can be a parameter without variable bit selects.
  function automatic logic [63:0] sext_shl(input logic [63:0] v,
                                           input int in_w,
                                           input int shift);
    logic signed [63:0] t;
    t = signed'(v << (64 - in_w));
    t = t >>> (64 - in_w);
    return t <<< shift;
  endfunction

endpackage

// File: rtl/fc_layer_serializer_if.sv
// fc_layer_serializer_if: bundle between an upstream FC layer (master)
// and the serializer (slave).
//   in_dat/in_valid : DIM-wide activation vector, one-cycle strobe
//   ovf_clr         : clears the sticky overflow flag
//   out_dat/out_valid/out_idx/out_last : serial element stream
//   busy            : serializer is streaming
//   ovf             : sticky, a vector was dropped
interface fc_layer_serializer_if
  import fc_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int IDX_W = idx_w(DIM)
);
  logic [IN_W-1:0]  in_dat [DIM];
  logic             in_valid;
  logic             ovf_clr;
  logic [OUT_W-1:0] out_dat;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;
  logic             ovf;

  modport master (output in_dat, in_valid, ovf_clr,
                  input  out_dat, out_valid, out_idx, out_last, busy, ovf);
  modport slave  (input  in_dat, in_valid, ovf_clr,
                  output out_dat, out_valid, out_idx, out_last, busy, ovf);
endinterface

// File: rtl/fc_layer_serializer_vec_buf.sv
// fc_vec_buf: DIM x IN_W vector register.
//   clk, rst_n : clock, synchronous active-low reset (clears contents)
//   ld         : capture din on this edge
//   din        : vector to capture
//   q          : stored vector; elements are read by index at the user
module fc_vec_buf #(
  parameter int DIM  = 8,
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld,
  input  logic [IN_W-1:0] din [DIM],
  output logic [IN_W-1:0] q   [DIM]
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '{default: '0};
    else if (ld) q <= din;
  end
endmodule

// File: rtl/fc_layer_serializer.sv
// fc_layer_serializer: captures a DIM-wide activation vector on a one-cycle
// strobe and replays it one element per cycle, sign-extended and shifted
// left by SHIFT, to the next layer's serial input.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fc_layer_serializer_if.slave (vector in, serial out,
//                busy, sticky ovf with ovf_clr)
// Optional macro FC_SER_DBUF_EN adds a one-deep shadow vector so a vector
// arriving mid-stream is queued instead of dropped.
module fc_layer_serializer
  import fc_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SHIFT = 4,
  parameter int IDX_W = idx_w(DIM)
) (
  input  logic clk,
  input  logic rst_n,
  fc_layer_serializer_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_SEND = 1'(SEND);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  if (OUT_W < IN_W + SHIFT) begin : g_bad_w
    $error("fc_layer_serializer: OUT_W must be >= IN_W + SHIFT");
  end
  if (DIM < 2) begin : g_bad_dim
    $error("fc_layer_serializer: DIM must be >= 2");
  end

  logic [0:0]       state, nxt_state;
  logic [IDX_W-1:0] cnt, nxt_cnt;
  logic             at_last, ld_main, drop;
  logic [IN_W-1:0]  main_din [DIM];
  logic [IN_W-1:0]  main_q   [DIM];
  logic [IN_W-1:0]  elem;

  fc_vec_buf #(.DIM(DIM), .IN_W(IN_W)) u_main (
    .clk(clk), .rst_n(rst_n), .ld(ld_main), .din(main_din), .q(main_q)
  );

`ifdef FC_SER_DBUF_EN
  logic             pend, nxt_pend, ld_sh;
  logic [IN_W-1:0]  sh_din [DIM];
  logic [IN_W-1:0]  sh_q   [DIM];

  always_comb sh_din = bus.in_dat;

  fc_vec_buf #(.DIM(DIM), .IN_W(IN_W)) u_shadow (
    .clk(clk), .rst_n(rst_n), .ld(ld_sh), .din(sh_din), .q(sh_q)
  );
`endif

  always_comb begin
    at_last   = (state == ST_SEND) && (cnt == LAST_IDX);
    nxt_state = state;
    nxt_cnt   = cnt;
    ld_main   = 1'b0;
    drop      = 1'b0;
    main_din  = bus.in_dat;
`ifdef FC_SER_DBUF_EN
    nxt_pend  = pend;
    ld_sh     = 1'b0;
`endif
    if (state == ST_IDLE) begin
      if (bus.in_valid) begin
        ld_main   = 1'b1;
        nxt_cnt   = '0;
        nxt_state = ST_SEND;
      end
    end else if (!at_last) begin
      nxt_cnt = cnt + 1'b1;
      if (bus.in_valid) begin
`ifdef FC_SER_DBUF_EN
        if (!pend) begin
          ld_sh    = 1'b1;
          nxt_pend = 1'b1;
        end else begin
          drop = 1'b1;   // shadow keeps the older vector
        end
`else
        drop = 1'b1;
`endif
      end
    end else begin
      // Last element: chain the next vector with no bubble if one exists.
      nxt_cnt = '0;
`ifdef FC_SER_DBUF_EN
      if (pend) begin
        ld_main  = 1'b1;
        main_din = sh_q;
        ld_sh    = bus.in_valid;   // a fresh arrival refills the shadow
        nxt_pend = bus.in_valid;
      end else
`endif
      if (bus.in_valid) ld_main   = 1'b1;
      else              nxt_state = ST_IDLE;
    end
    // Element to present next cycle: element 0 of a vector being loaded now,
    // otherwise the next element of the held vector.
    elem = ld_main ? main_din[0] : main_q[nxt_cnt];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bus.ovf       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_dat   <= '0;
`ifdef FC_SER_DBUF_EN
      pend          <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
`ifdef FC_SER_DBUF_EN
      pend  <= nxt_pend;
`endif
      if (drop)             bus.ovf <= 1'b1;
      else if (bus.ovf_clr) bus.ovf <= 1'b0;
      bus.busy      <= (nxt_state == ST_SEND);
      bus.out_valid <= (nxt_state == ST_SEND);
      bus.out_last  <= (nxt_state == ST_SEND) && (nxt_cnt == LAST_IDX);
      bus.out_idx   <= (nxt_state == ST_SEND) ? nxt_cnt : '0;
      bus.out_dat   <= (nxt_state == ST_SEND) ?
                       OUT_W'(sext_shl(64'(elem), IN_W, SHIFT)) : '0;
    end
  end
endmodule

// File: tb/tb_fc_layer_serializer.sv
module tb_fc_layer_serializer;
  localparam int DIM   = 8;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int SHIFT = 4;
  localparam int IDX_W = 3;
`ifdef FC_SER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef logic [IN_W-1:0] vec_t [DIM];
  typedef struct {
    logic [OUT_W-1:0] dat;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  logic clk, rst_n;
  int   npass, ntotal, nfail;
  exp_t sb[$];

  fc_layer_serializer_if #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  fc_layer_serializer #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0] x);
    logic signed [OUT_W-1:0] s;
    s = {{(OUT_W-IN_W){x[IN_W-1]}}, x};
    return s <<< SHIFT;
  endfunction

  task automatic push_vec(input vec_t v);
    for (int i = 0; i < DIM; i++)
      sb.push_back('{dat: scale(v[i]), idx: IDX_W'(i), last: (i == DIM-1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input vec_t v, input bit accept, input bit clr);
    bus.in_dat   = v;
    bus.in_valid = 1'b1;
    bus.ovf_clr  = clr;
    if (accept) push_vec(v);
    tick();
    bus.in_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < 200), 32'd1);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_dat"},   32'(bus.out_dat),   32'd0);
    check({tag, "_out_idx"},   32'(bus.out_idx),   32'd0);
    check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_ovf"},       32'(bus.ovf),       32'd0);
  endtask

  // Scoreboard monitor: every valid element must match the oldest expected.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_dat",  32'(bus.out_dat),  32'(e.dat));
        check("out_idx",  32'(bus.out_idx),  32'(e.idx));
        check("out_last", 32'(bus.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    vec_t v0, va, vb, vc;
    logic [OUT_W-1:0] exp0 [DIM];
    int gap;
    npass = 0; ntotal = 0; nfail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.in_dat   = '{default: '0};
    v0   = '{8'h7F, 8'h81, 8'h00, 8'h01, 8'hFF, 8'h40, 8'hC0, 8'h10};
    exp0 = '{16'h07F0, 16'hF810, 16'h0000, 16'h0010, 16'hFFF0, 16'h0400, 16'hFC00, 16'h0100};
    for (int i = 0; i < DIM; i++) begin
      va[i] = IN_W'(8'h11 * (i + 1));
      vb[i] = IN_W'(8'hA0 + i);
      vc[i] = IN_W'(8'h55 ^ i);
    end

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single vector with fixed expected values
    for (int i = 0; i < DIM; i++)
      sb.push_back('{dat: exp0[i], idx: IDX_W'(i), last: (i == DIM-1)});
    strobe(v0, 1'b0, 1'b0);
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("lat_busy",  32'(bus.busy),      32'd1);
    check("lat_idx0",  32'(bus.out_idx),   32'd0);
    repeat (DIM-1) tick();
    check("single_last", 32'(bus.out_last), 32'd1);
    tick();
    check("single_after_valid", 32'(bus.out_valid), 32'd0);
    check("single_after_busy",  32'(bus.busy),      32'd0);

    // Next vector coincident with last element: no bubble
    strobe(va, 1'b1, 1'b0);
    repeat (DIM-1) tick();
    check("b2b_at_last", 32'(bus.out_last), 32'd1);
    strobe(vb, 1'b1, 1'b0);
    check("b2b_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_idx0",  32'(bus.out_idx),   32'd0);
    drain("b2b");
    check("b2b_ovf", 32'(bus.ovf), 32'd0);

    // Mid-stream arrivals: B at t+3 (queued only with shadow), C at t+4 dropped
    strobe(va, 1'b1, 1'b0);
    repeat (2) tick();
    strobe(vb, DBUF, 1'b0);
    check("b_arrival_ovf", 32'(bus.ovf), DBUF ? 32'd0 : 32'd1);
    strobe(vc, 1'b0, 1'b0);
    check("c_drop_ovf", 32'(bus.ovf), 32'd1);
    repeat (DIM-4) tick();
    check("chain_valid", 32'(bus.out_valid), DBUF ? 32'd1 : 32'd0);
    check("chain_idx",   32'(bus.out_idx),   32'd0);
    drain("ovf");
    check("ovf_sticky", 32'(bus.ovf), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.ovf), 32'd0);

    // Drop coincident with ovf_clr: set wins
    strobe(va, 1'b1, 1'b0);
    repeat (2) tick();
    strobe(vb, DBUF, 1'b0);
    strobe(vc, 1'b0, 1'b1);
    check("set_wins", 32'(bus.ovf), 32'd1);
    drain("setwins");

    // Reset mid-stream
    strobe(va, 1'b1, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check_zero("midrst");
    sb.delete();
    rst_n = 1'b1;
    tick();
    strobe(vc, 1'b1, 1'b0);
    check("restart_idx0", 32'(bus.out_idx), 32'd0);
    drain("restart");

    // Random data at rates no faster than one vector per DIM cycles
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < DIM; i++) va[i] = IN_W'($urandom);
      gap = $urandom_range(DIM + 3, DIM);
      strobe(va, 1'b1, 1'b0);
      repeat (gap - 1) tick();
    end
    drain("random");
    check("random_ovf", 32'(bus.ovf), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
